block_xfer_seq: RTL and testbench

Multi-register transfer sequencer for LDM/STM. It walks a 16-bit register list in ascending register order and issues one word memory transaction per set bit. Loads are written into the register bank through its write port; stores read the bank through a combinational read port. It also performs optional base-register writeback. It sits between the decode/control unit and the register bank and memory interface, acting as the initiator of register-bank writes.

---
 rtl/block_xfer_seq_pkg.sv | 23 ++
 rtl/block_xfer_seq_reg_list_scan.sv | 26 ++
 rtl/block_xfer_seq.sv | 167 ++++++++++++++++
 tb/tb_block_xfer_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_xfer_seq_pkg.sv
// Shared types and constants for the LDM/STM block transfer sequencer.
package block_xfer_seq_pkg;

    localparam int WORD_BYTES = 4;
    localparam int LIST_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        REQ,
        LWR,
        WB,
        DONE
    } state_e;

    typedef struct packed {
        logic load;
        logic pre;
        logic up;
        logic writeback;
    } xfer_mode_t;

endpackage

// File: rtl/block_xfer_seq_reg_list_scan.sv
// Combinational scan of a register bitmap: lowest set index, any-set flag
// and population count.
module reg_list_scan
    import block_xfer_seq_pkg::*;
(
    input  logic [LIST_W-1:0] list,
    output logic [3:0]        idx,
    output logic              found,
    output logic [4:0]        count
);

    // Walk downwards so the last hit written is the lowest set bit.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        count = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (list[i]) begin
                idx   = 4'(i);
                found = 1'b1;
                count = count + 5'd1;
            end
        end
    end

endmodule

// File: rtl/block_xfer_seq.sv
// LDM/STM sequencer: walks the register list in ascending order, issues one
// word transaction per register, then performs optional base writeback.
module block_xfer_seq
    import block_xfer_seq_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = block_xfer_seq_pkg::WORD_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       reg_list,
    input  logic [3:0]        rn,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              load,
    input  logic              pre,
    input  logic              up,
    input  logic              writeback,
    output logic              busy,
    output logic              done,
    output logic [3:0]        reg_sel,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              reg_wr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

    state_e            state_q, state_d;
    logic [15:0]       list_q, list_d;
    logic [3:0]        rn_q, rn_d;
    xfer_mode_t        mode_q, mode_d;
    logic              rn_hit_q, rn_hit_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] final_q, final_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [3:0]        cur_q, cur_d;

    logic [3:0]        scan_idx;
    logic              scan_found;
    logic [4:0]        scan_count;
    logic [ADDR_W-1:0] span;

    reg_list_scan u_scan (
        .list  (list_q),
        .idx   (scan_idx),
        .found (scan_found),
        .count (scan_count)
    );

    assign span = ADDR_W'(scan_count) * STRIDE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            list_q   <= '0;
            rn_q     <= '0;
            mode_q   <= '0;
            rn_hit_q <= 1'b0;
            addr_q   <= '0;
            final_q  <= '0;
            data_q   <= '0;
            cur_q    <= '0;
        end else begin
            state_q  <= state_d;
            list_q   <= list_d;
            rn_q     <= rn_d;
            mode_q   <= mode_d;
            rn_hit_q <= rn_hit_d;
            addr_q   <= addr_d;
            final_q  <= final_d;
            data_q   <= data_d;
            cur_q    <= cur_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        list_d    = list_q;
        rn_d      = rn_q;
        mode_d    = mode_q;
        rn_hit_d  = rn_hit_q;
        addr_d    = addr_q;
        final_d   = final_q;
        data_d    = data_q;
        cur_d     = cur_q;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        reg_sel   = '0;
        reg_wr    = 1'b0;
        reg_wdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                // addr_q temporarily holds the base until SETUP turns it into the start address.
                if (start) begin
                    list_d   = reg_list;
                    rn_d     = rn;
                    mode_d   = '{load: load, pre: pre, up: up, writeback: writeback};
                    rn_hit_d = reg_list[rn];
                    addr_d   = base_addr;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (mode_q.up) begin
                    addr_d  = addr_q + (mode_q.pre ? STRIDE : '0);
                    final_d = addr_q + span;
                end else begin
                    addr_d  = addr_q - span + (mode_q.pre ? '0 : STRIDE);
                    final_d = addr_q - span;
                end
                state_d = scan_found ? REQ : DONE;
            end
            REQ: begin
                reg_sel   = scan_idx;
                mem_req   = 1'b1;
                mem_we    = !mode_q.load;
                mem_addr  = addr_q;
                mem_wdata = mode_q.load ? '0 : reg_rdata;
                if (mem_ack) begin
                    list_d = list_q & ~(16'd1 << scan_idx);
                    addr_d = addr_q + STRIDE;
                    if (mode_q.load) begin
                        data_d  = mem_rdata;
                        cur_d   = scan_idx;
                        state_d = LWR;
                    end else begin
                        state_d = (scan_count > 5'd1) ? REQ : WB;
                    end
                end
            end
            LWR: begin
                reg_wr    = 1'b1;
                reg_sel   = cur_q;
                reg_wdata = data_q;
                state_d   = (list_q != '0) ? REQ : WB;
            end
            WB: begin
                // A loaded base register keeps the loaded value instead of the writeback.
                if (mode_q.writeback && !(mode_q.load && rn_hit_q)) begin
                    reg_wr    = 1'b1;
                    reg_sel   = rn_q;
                    reg_wdata = DATA_W'(final_q);
                end
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_block_xfer_seq.sv
// Self-checking bench for block_xfer_seq: a transaction-level model predicts
// memory and register-bank traffic, a monitor compares it cycle by cycle.
module tb_block_xfer_seq;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } mem_t;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] data;
    } reg_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] reg_list = '0;
    logic [3:0]  rn = '0;
    logic [31:0] base_addr = '0;
    logic        load = 1'b0;
    logic        pre = 1'b0;
    logic        up = 1'b0;
    logic        writeback = 1'b0;
    logic        busy, done, reg_wr, mem_req, mem_we;
    logic [3:0]  reg_sel;
    logic [31:0] reg_rdata, reg_wdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack = 1'b0;

    logic [31:0] bank [16];
    mem_t        exp_mem[$];
    mem_t        act_mem[$];
    reg_t        exp_reg[$];
    reg_t        act_reg[$];

    int vectors = 0;
    int miscompares = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    int busy_cnt = 0;
    int first_req = 0;
    int exp_busy = 0;
    int exp_n_mem = 0;
    int exp_n_reg = 0;
    bit done_seen = 1'b0;
    bit held = 1'b0;
    logic [31:0] held_addr, held_wdata;

    always #5 clk = ~clk;

    assign reg_rdata = bank[reg_sel];
    assign mem_rdata = mem_addr ^ 32'h0000_F0F0;

    block_xfer_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .reg_list  (reg_list),
        .rn        (rn),
        .base_addr (base_addr),
        .load      (load),
        .pre       (pre),
        .up        (up),
        .writeback (writeback),
        .busy      (busy),
        .done      (done),
        .reg_sel   (reg_sel),
        .reg_rdata (reg_rdata),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Transfer model: registers ascending, addresses ascending from the lowest word touched.
    task automatic build_model(input logic [15:0] list, input logic [3:0] rn_i,
                               input logic [31:0] base, input logic ld, input logic pr,
                               input logic u, input logic w, input int delay);
        int n;
        logic [31:0] a;
        logic [31:0] fin;
        n = 0;
        for (int i = 0; i < 16; i++) if (list[i]) n++;
        if (u) begin
            a   = base + (pr ? 32'd4 : 32'd0);
            fin = base + 32'(4 * n);
        end else begin
            a   = base - 32'(4 * n) + (pr ? 32'd0 : 32'd4);
            fin = base - 32'(4 * n);
        end
        exp_mem.delete();
        exp_reg.delete();
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                exp_mem.push_back('{a, !ld, ld ? 32'd0 : bank[i]});
                if (ld) exp_reg.push_back('{4'(i), a ^ 32'h0000_F0F0});
                a = a + 32'd4;
            end
        end
        if (n > 0 && w && !(ld && list[rn_i])) exp_reg.push_back('{rn_i, fin});
        exp_n_mem = exp_mem.size();
        exp_n_reg = exp_reg.size();
        exp_busy  = (n == 0) ? 2 : 3 + n * (delay + 1) + (ld ? n : 0);
    endtask

    task automatic applyStimulus(input logic [15:0] list, input logic [3:0] rn_i,
                                 input logic [31:0] base, input logic ld, input logic pr,
                                 input logic u, input logic w, input int delay);
        build_model(list, rn_i, base, ld, pr, u, w, delay);
        ack_delay = delay;
        busy_cnt  = 0;
        first_req = 0;
        done_seen = 1'b0;
        act_mem.delete();
        act_reg.delete();
        @(negedge clk);
        reg_list  = list;
        rn        = rn_i;
        base_addr = base;
        load      = ld;
        pre       = pr;
        up        = u;
        writeback = w;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit pulse);
        for (int i = 0; i < 300 && !done_seen; i++) begin
            @(negedge clk);
            start = pulse && (i % 3 == 0) && busy && !done;
        end
        start = 1'b0;
        checkOutput({tag, " done_seen"}, 32'(done_seen), 32'd1);
        @(negedge clk);
        checkOutput({tag, " idle_after"}, {29'd0, busy, mem_req, reg_wr}, 32'd0);
        checkOutput({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        checkOutput({tag, " mem_count"}, 32'(act_mem.size()), 32'(exp_n_mem));
        checkOutput({tag, " reg_count"}, 32'(act_reg.size()), 32'(exp_n_reg));
    endtask

    // Memory responder and per-cycle compare against the model queues.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
                held     = 1'b0;
            end else begin
                if (mem_req) begin
                    if (wait_cnt >= ack_delay) begin
                        mem_ack  = 1'b1;
                        wait_cnt = 0;
                    end else begin
                        mem_ack  = 1'b0;
                        wait_cnt++;
                    end
                end else begin
                    mem_ack  = 1'b0;
                    wait_cnt = 0;
                end
                if (busy) begin
                    busy_cnt++;
                    checkOutput("req_wr_exclusive", 32'(mem_req & reg_wr), 32'd0);
                end
                if (mem_req && first_req == 0) first_req = busy_cnt;
                if (held) begin
                    checkOutput("hold_req", 32'(mem_req), 32'd1);
                    checkOutput("hold_addr", mem_addr, held_addr);
                    checkOutput("hold_wdata", mem_wdata, held_wdata);
                end
                held       = mem_req && !mem_ack;
                held_addr  = mem_addr;
                held_wdata = mem_wdata;
                if (mem_req && mem_ack) begin
                    act_mem.push_back('{mem_addr, mem_we, mem_wdata});
                    if (exp_mem.size() > 0) begin
                        mem_t e;
                        e = exp_mem.pop_front();
                        checkOutput("mem_addr", mem_addr, e.addr);
                        checkOutput("mem_we", 32'(mem_we), 32'(e.we));
                        checkOutput("mem_wdata", mem_wdata, e.data);
                    end
                end
                if (reg_wr) begin
                    act_reg.push_back('{reg_sel, reg_wdata});
                    if (exp_reg.size() > 0) begin
                        reg_t r;
                        r = exp_reg.pop_front();
                        checkOutput("reg_sel", 32'(reg_sel), 32'(r.sel));
                        checkOutput("reg_wdata", reg_wdata, r.data);
                    end
                    bank[reg_sel] = reg_wdata;
                end
                if (done) begin
                    done_seen = 1'b1;
                    checkOutput("done_with_busy", 32'(busy), 32'd1);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) bank[i] = 32'h1111_0000 + 32'(i);
        #12;
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst reg_sel", 32'(reg_sel), 32'd0);
        checkOutput("rst reg_wr", 32'(reg_wr), 32'd0);
        checkOutput("rst reg_wdata", reg_wdata, 32'd0);
        checkOutput("rst mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst mem_addr", mem_addr, 32'd0);
        checkOutput("rst mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // STMIA R0!,{R1,R2}
        bank[0] = 32'h100; bank[1] = 32'hAAAA; bank[2] = 32'hBBBB;
        applyStimulus(16'h0006, 4'd0, 32'h100, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        wait_done("stmia", 1'b0);
        checkOutput("stmia first_req", 32'(first_req), 32'd2);
        checkOutput("stmia busy_lit", 32'(busy_cnt), 32'd5);
        if (act_mem.size() == 2 && act_reg.size() == 1) begin
            checkOutput("stmia addr0", act_mem[0].addr, 32'h100);
            checkOutput("stmia data0", act_mem[0].data, 32'hAAAA);
            checkOutput("stmia addr1", act_mem[1].addr, 32'h104);
            checkOutput("stmia data1", act_mem[1].data, 32'hBBBB);
            checkOutput("stmia wb", act_reg[0].data, 32'h108);
        end

        // LDMDB R3!,{R4,R7,R9}
        applyStimulus(16'h0290, 4'd3, 32'h200, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        wait_done("ldmdb", 1'b0);
        checkOutput("ldmdb busy_lit", 32'(busy_cnt), 32'd9);
        if (act_mem.size() == 3 && act_reg.size() == 4) begin
            checkOutput("ldmdb addr0", act_mem[0].addr, 32'h1F4);
            checkOutput("ldmdb addr2", act_mem[2].addr, 32'h1FC);
            checkOutput("ldmdb r4", {act_reg[0].sel, act_reg[0].data[27:0]}, {4'd4, 28'hF104});
            checkOutput("ldmdb r7", {act_reg[1].sel, act_reg[1].data[27:0]}, {4'd7, 28'hF108});
            checkOutput("ldmdb r9", {act_reg[2].sel, act_reg[2].data[27:0]}, {4'd9, 28'hF10C});
            checkOutput("ldmdb wb", {act_reg[3].sel, act_reg[3].data[27:0]}, {4'd3, 28'h1F4});
        end

        // LDMIA R5!,{R5,R6}: loaded base suppresses writeback
        applyStimulus(16'h0060, 4'd5, 32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        wait_done("ldmia", 1'b0);
        checkOutput("ldmia nregs", 32'(act_reg.size()), 32'd2);
        checkOutput("ldmia bank5", bank[5], 32'hF0B0);
        checkOutput("ldmia bank6", bank[6], 32'hF0B4);

        // STMIB with 3 wait cycles per request and stray start pulses
        bank[1] = 32'h1234_5678; bank[3] = 32'h9ABC_DEF0;
        applyStimulus(16'h000A, 4'd2, 32'h1000, 1'b0, 1'b1, 1'b1, 1'b0, 3);
        wait_done("stmib", 1'b1);
        checkOutput("stmib busy_lit", 32'(busy_cnt), 32'd11);
        if (act_mem.size() == 2) begin
            checkOutput("stmib addr0", act_mem[0].addr, 32'h1004);
            checkOutput("stmib data0", act_mem[0].data, 32'h1234_5678);
            checkOutput("stmib addr1", act_mem[1].addr, 32'h1008);
            checkOutput("stmib data1", act_mem[1].data, 32'h9ABC_DEF0);
        end

        // Empty list with writeback requested
        applyStimulus(16'h0000, 4'd4, 32'h300, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        wait_done("empty", 1'b0);
        checkOutput("empty busy_lit", 32'(busy_cnt), 32'd2);
        checkOutput("empty no_req", 32'(first_req), 32'd0);

        // Reset while REQ waits for an ack that never comes
        applyStimulus(16'h0003, 4'd0, 32'h500, 1'b0, 1'b0, 1'b1, 1'b1, 100);
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        checkOutput("abort req_seen", 32'(mem_req), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("abort mem_req", 32'(mem_req), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort reg_wr", 32'(reg_wr), 32'd0);
        checkOutput("abort mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        exp_mem.delete();
        exp_reg.delete();
        ack_delay = 0;
        rst = 1'b1;

        // STMDB R13!,{R1,R2} wrapping below address zero
        bank[1] = 32'hCAFE_0001; bank[2] = 32'hCAFE_0002;
        applyStimulus(16'h0006, 4'd13, 32'h4, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        wait_done("wrap", 1'b0);
        if (act_mem.size() == 2 && act_reg.size() == 1) begin
            checkOutput("wrap addr0", act_mem[0].addr, 32'hFFFF_FFFC);
            checkOutput("wrap addr1", act_mem[1].addr, 32'h0);
            checkOutput("wrap wb", act_reg[0].data, 32'hFFFF_FFFC);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
